fast_fifo_input_reg: RTL and testbench
======================================

FAST_FIFO_INPUT_REG -- requirements
Module: fast_fifo_input_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which is the data width in bits.
REQ-002 SHALL have parameter PIPE_STAGES, default 2, which is the number of register stages from grab to writeEnable (range 1..4).
REQ-003 SHALL have parameter OVERRUN_BUDGET, default 8, which is the maximum writes allowed after almostFull is seen high (FIFO margin minus latency).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port dataAvailable, input, 1 bit: the upstream lookahead source holds a valid word.
REQ-007 SHALL have port dataIn, input, WIDTH bits: the upstream word, valid while dataAvailable=1.
REQ-008 SHALL have port grab, output, 1 bit: combinational consume strobe to upstream.
REQ-009 SHALL have port almostFull, input, 1 bit: registered almost-full flag from the FIFO write side.
REQ-010 SHALL have port writeEnable, output, 1 bit: registered FIFO write strobe.
REQ-011 SHALL have port dataOut, output, WIDTH bits: registered FIFO write data.
REQ-012 SHALL have port stall, input, 1 bit: software/control pause; when high, no new grabs are issued.
REQ-013 SHALL have port writeCount, output, 32 bits: total writes issued since reset, wrapping.
REQ-014 SHALL have port overrunError, output, 1 bit: sticky flag, set when the overrun budget is exceeded.

Function
REQ-015 SHALL drive grab = dataAvailable && !almostFull && !stall && !overrunError; grab is combinational, with no register between these inputs and grab.
REQ-016 SHALL consume exactly one upstream word per cycle in which grab=1; back-to-back grabs in consecutive cycles are allowed, giving 1 word/cycle throughput.
REQ-017 SHALL launch dataIn and a valid bit into a PIPE_STAGES-deep shift pipe on grab; writeEnable/dataOut SHALL equal the pipe tail, so grab in cycle N gives writeEnable=1 in cycle N+PIPE_STAGES.
REQ-018 SHALL never drop, duplicate, or reorder words; the writeEnable sequence SHALL equal the grab sequence delayed by PIPE_STAGES.
REQ-019 SHALL drive dataOut=0 whenever writeEnable=0, which forces the data to zero when not valid.
REQ-020 SHALL not cancel in-flight pipe entries when almostFull rises; they complete normally.
REQ-021 SHALL maintain an overrun counter, OVERRUN_BUDGET+1 wide with saturation: it clears in a cycle with almostFull=0 and increments on each writeEnable=1 cycle while almostFull=1.
REQ-022 SHALL set overrunError in the cycle after the overrun counter exceeds OVERRUN_BUDGET; overrunError SHALL stay set until reset, and while set grab is held at 0.
REQ-023 SHALL increment writeCount by 1 per writeEnable cycle, wrapping 2^32-1 -> 0.
REQ-024 SHALL give precedence to almostFull when stall deasserts in the same cycle that almostFull asserts: grab=0.
REQ-025 SHALL ignore upstream data when dataAvailable=0 with almostFull=0: grab=0 and no pipe entry.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously clear all pipe valid bits, writeEnable=0, dataOut=0, writeCount=0, the overrun counter, and overrunError=0.
REQ-027 SHALL discard in-flight words when reset is asserted mid-operation; no writeEnable SHALL occur until a fresh grab after deassertion.
REQ-028 SHALL hold grab=0 while rst_n=0.
REQ-029 SHALL deassert reset synchronously to clk, handled externally; the block SHALL accept grab in the first cycle after release.

Structure
REQ-030 SHALL place nothing in a shared package; the constants are module parameters only.
REQ-031 SHALL implement the valid/data pipe with the existing hyperpipe sub-module for the valid bit plus a parallel data shift register; no other sub-modules.
REQ-032 SHALL be sized for 120-200 lines of RTL.

Verification
REQ-033 SHALL cover streaming: dataAvailable=1 constant, words 1..100, almostFull=0 -> writeEnable 100 consecutive cycles starting 2 cycles after first grab, dataOut 1..100, writeCount=100.
REQ-034 SHALL cover backpressure: almostFull=1 for cycles 10..19 -> grab=0 in cycles 10..19, at most 2 writes while it is high, overrunError=0, and no word lost after resume.
REQ-035 SHALL cover overrun: PIPE_STAGES=2, OVERRUN_BUDGET=1, almostFull held high with 2 words in flight -> overrunError=1 one cycle after the second write, grab=0 thereafter.
REQ-036 SHALL cover reset mid-flight: 2 words in pipe, rst_n pulsed low -> no writeEnable afterwards, writeCount=0.
REQ-037 SHALL cover wrap: writeCount forced to 0xFFFFFFFF, one write -> writeCount=0.
REQ-038 SHALL cover intermittent source: random dataAvailable/stall patterns (10k cycles) -> FIFO-side word stream identical to source order, scoreboard match.

Source files
------------

// File: rtl/fast_fifo_input_reg_hyperpipe.sv
// Reset-clearable single-bit delay line of STAGES flops.
// Carries the valid bit alongside the data pipe in the FIFO input register.
module fast_fifo_input_reg_hyperpipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic validIn,
    output logic validOut
);
    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= validIn;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign validOut = pipe[STAGES-1];
endmodule

// File: rtl/fast_fifo_input_reg.sv
// Moves words from a lookahead source into a FIFO write port through a fixed-latency pipe,
// counting writes and flagging (sticky) any write burst that overruns the almost-full margin.
module fast_fifo_input_reg #(
    parameter int WIDTH          = 16,
    parameter int PIPE_STAGES    = 2,
    parameter int OVERRUN_BUDGET = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dataAvailable,
    input  logic [WIDTH-1:0] dataIn,
    output logic             grab,
    input  logic             almostFull,
    output logic             writeEnable,
    output logic [WIDTH-1:0] dataOut,
    input  logic             stall,
    output logic [31:0]      writeCount,
    output logic             overrunError
);
    localparam int            CW    = OVERRUN_BUDGET + 1;
    localparam logic [CW-1:0] LIMIT = CW'(OVERRUN_BUDGET);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [WIDTH-1:0] dataPipe [PIPE_STAGES];
    logic [CW-1:0]    overCount;
    logic [CW-1:0]    overCountNext;

    // Handshake: dataAvailable is the upstream valid and grab is the accept; the source
    // advances to its next word on every rising edge where grab=1 (one word per edge).
    assign grab = rst_n && dataAvailable && !almostFull && !stall && !overrunError;

    fast_fifo_input_reg_hyperpipe #(
        .STAGES(PIPE_STAGES)
    ) validPipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .validIn (grab),
        .validOut(writeEnable)
    );

    // Data enters zeroed when not grabbed, so the tail is already zero whenever invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                dataPipe[i] <= '0;
            end
        end else begin
            dataPipe[0] <= grab ? dataIn : '0;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                dataPipe[i] <= dataPipe[i-1];
            end
        end
    end

    assign dataOut = dataPipe[PIPE_STAGES-1];

    always_comb begin
        overCountNext = overCount;
        if (!almostFull) begin
            overCountNext = '0;
        end else if (writeEnable && (overCount != '1)) begin
            overCountNext = overCount + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overCount    <= '0;
            overrunError <= 1'b0;
            writeCount   <= 32'd0;
        end else begin
            overCount <= overCountNext;
            if (overCountNext > LIMIT) begin
                overrunError <= 1'b1;
            end
            if (writeEnable) begin
                writeCount <= writeCount + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fast_fifo_input_reg.sv
// Bench for fast_fifo_input_reg: directed scenarios with literal expectations plus a
// delay-queue reference model compared against the DUT on every falling edge.
module tb_fast_fifo_input_reg;
    localparam int WIDTH  = 16;
    localparam int PIPE   = 2;
    localparam int BUDGET = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dataAvailable;
    logic [WIDTH-1:0] dataIn;
    logic             grab;
    logic             almostFull;
    logic             writeEnable;
    logic [WIDTH-1:0] dataOut;
    logic             stall;
    logic [31:0]      writeCount;
    logic             overrunError;

    logic             da2;
    logic [WIDTH-1:0] din2;
    logic             af2;
    logic             grab2;
    logic             we2;
    logic [WIDTH-1:0] dout2;
    logic [31:0]      wc2;
    logic             err2;

    int testsRun    = 0;
    int testsFailed = 0;

    // reference model state
    logic [WIDTH-1:0] exp_q[$];
    int               dueQ[$];
    int               cycle      = 0;
    logic [31:0]      modelCount = 32'd0;
    int               ovCnt      = 0;
    bit               modelErr   = 1'b0;

    always #5 clk = ~clk;

    fast_fifo_input_reg #(
        .WIDTH(WIDTH), .PIPE_STAGES(PIPE), .OVERRUN_BUDGET(BUDGET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dataAvailable(dataAvailable), .dataIn(dataIn),
        .grab(grab), .almostFull(almostFull), .writeEnable(writeEnable), .dataOut(dataOut),
        .stall(stall), .writeCount(writeCount), .overrunError(overrunError)
    );

    fast_fifo_input_reg #(
        .WIDTH(WIDTH), .PIPE_STAGES(2), .OVERRUN_BUDGET(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .dataAvailable(da2), .dataIn(din2),
        .grab(grab2), .almostFull(af2), .writeEnable(we2), .dataOut(dout2),
        .stall(1'b0), .writeCount(wc2), .overrunError(err2)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit da, input logic [WIDTH-1:0] d, input bit af, input bit st);
        dataAvailable = da;
        dataIn        = d;
        almostFull    = af;
        stall         = st;
    endtask

    // Reference model: words grabbed are queued with the cycle they must appear on the write side.
    always @(negedge clk) begin : compare
        bit               expGrab;
        bit               expWe;
        logic [WIDTH-1:0] expData;
        if (!rst_n) begin
            exp_q.delete();
            dueQ.delete();
            modelCount = 32'd0;
            ovCnt      = 0;
            modelErr   = 1'b0;
        end
        expWe   = (dueQ.size() > 0) && (dueQ[0] == cycle);
        expData = expWe ? exp_q[0] : '0;
        expGrab = rst_n && dataAvailable && !almostFull && !stall && !modelErr;
        check("model_grab", 32'(grab), 32'(expGrab));
        check("model_we", 32'(writeEnable), 32'(expWe));
        check("model_data", 32'(dataOut), 32'(expData));
        check("model_count", writeCount, modelCount);
        check("model_err", 32'(overrunError), 32'(modelErr));
        if (rst_n) begin
            if (expWe) begin
                void'(exp_q.pop_front());
                void'(dueQ.pop_front());
                modelCount = modelCount + 32'd1;
            end
            if (!almostFull) ovCnt = 0;
            else if (expWe) ovCnt++;
            if (ovCnt > BUDGET) modelErr = 1'b1;
            if (expGrab) begin
                exp_q.push_back(dataIn);
                dueQ.push_back(cycle + PIPE);
            end
        end
        cycle++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int weDuring;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        da2 = 1'b0; din2 = '0; af2 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_we", 32'(writeEnable), 32'd0);
        check("reset_dout", 32'(dataOut), 32'd0);
        check("reset_count", writeCount, 32'd0);
        check("reset_err", 32'(overrunError), 32'd0);
        check("reset_grab", 32'(grab), 32'd0);

        // streaming 1..100, first grab in the cycle reset releases
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 102; i++) begin
            if (i > 1) tick();
            drive(i <= 100, (i <= 100) ? WIDTH'(i) : '0, 1'b0, 1'b0);
            @(negedge clk);
            check("stream_grab", 32'(grab), (i <= 100) ? 32'd1 : 32'd0);
            if (i >= 3) begin
                check("stream_we", 32'(writeEnable), 32'd1);
                check("stream_data", 32'(dataOut), 32'(i - 2));
            end else begin
                check("stream_we_lat", 32'(writeEnable), 32'd0);
            end
        end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("stream_count", writeCount, 32'd100);
        check("stream_idle", 32'(writeEnable), 32'd0);

        // backpressure: almostFull high for k = 10..19
        weDuring = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            drive(1'b1, WIDTH'(16'h1000 + k), (k >= 10) && (k <= 19), 1'b0);
            @(negedge clk);
            if (k >= 10 && k <= 19) begin
                check("bp_grab", 32'(grab), 32'd0);
                weDuring += int'(writeEnable);
            end
        end
        check("bp_writes", 32'(weDuring), 32'd2);
        check("bp_err", 32'(overrunError), 32'd0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (4) tick();

        // stall release coinciding with almostFull rise
        drive(1'b1, 16'h00AA, 1'b0, 1'b1);
        @(negedge clk);
        check("stall_grab", 32'(grab), 32'd0);
        tick();
        drive(1'b1, 16'h00AA, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_af_prec", 32'(grab), 32'd0);
        tick();
        drive(1'b1, 16'h00AA, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_resume", 32'(grab), 32'd1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("no_data_grab", 32'(grab), 32'd0);
        repeat (4) tick();

        // reset with two words in flight
        drive(1'b1, 16'h0C01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0C02, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_we", 32'(writeEnable), 32'd0);
        check("rst_mid_grab", 32'(grab), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_mid_after_we", 32'(writeEnable), 32'd0);
            check("rst_mid_after_count", writeCount, 32'd0);
            tick();
        end

        // intermittent source, order checked by the model
        for (int n = 0; n < 10000; n++) begin
            tick();
            drive($urandom_range(0, 99) < 70, WIDTH'($urandom_range(0, 65535)),
                  almostFull ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 9) == 0);
        end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (6) tick();
        @(negedge clk);
        check("rand_err", 32'(overrunError), 32'd0);

        // overrun on the budget-1 instance
        tick();
        da2 = 1'b1; din2 = 16'hA001; af2 = 1'b0;
        @(negedge clk);
        check("ovr_grab0", 32'(grab2), 32'd1);
        tick();
        din2 = 16'hA002;
        @(negedge clk);
        check("ovr_grab1", 32'(grab2), 32'd1);
        tick();
        din2 = 16'hA003; af2 = 1'b1;
        @(negedge clk);
        check("ovr_grab_af", 32'(grab2), 32'd0);
        check("ovr_we1", 32'(we2), 32'd1);
        check("ovr_d1", 32'(dout2), 32'hA001);
        check("ovr_err_t2", 32'(err2), 32'd0);
        tick();
        @(negedge clk);
        check("ovr_we2", 32'(we2), 32'd1);
        check("ovr_d2", 32'(dout2), 32'hA002);
        check("ovr_err_t3", 32'(err2), 32'd0);
        tick();
        af2 = 1'b0;
        @(negedge clk);
        check("ovr_err_set", 32'(err2), 32'd1);
        check("ovr_grab_blocked", 32'(grab2), 32'd0);
        check("ovr_we_idle", 32'(we2), 32'd0);
        check("ovr_count", wc2, 32'd2);
        tick();
        @(negedge clk);
        check("ovr_err_sticky", 32'(err2), 32'd1);
        check("ovr_grab_still", 32'(grab2), 32'd0);
        da2 = 1'b0;

        // writeCount wrap
        tick();
        force dut.writeCount = 32'hFFFF_FFFF;
        modelCount = 32'hFFFF_FFFF;
        @(negedge clk);
        tick();
        release dut.writeCount;
        drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("wrap_we", 32'(writeEnable), 32'd1);
        check("wrap_before", writeCount, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        check("wrap_after", writeCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
